seg7_msg_writer: RTL
====================

# seg7_msg_writer

Message source for the 8-digit 7-segment display path. Holds a host-written ASCII message and drives it into the display controller's character port as one `clear` pulse followed by eight `char_valid` characters per frame. Operates in static mode (one frame) or scroll mode, where it repeatedly re-sends an 8-character window advanced by one position every `SCROLL_DIV` cycles. Runs on the display scan clock, so every strobe it emits is sampled exactly once by the controller.

## Interface

Parameters:
- `MSG_DEPTH`, default 16: message buffer size in bytes. Must be a power of 2 and at least 8.
- `SCROLL_DIV`, default 250: hold cycles between scroll frames (0.5 s at 500 Hz). Minimum value is 1.

Ports:
- `clk_500hz`  in  1  display/scan clock, the only clock.
- `rst`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  message buffer write strobe.
- `wr_addr`  in  log2(MSG_DEPTH)  buffer byte address.
- `wr_data`  in  8  ASCII byte to write.
- `msg_len`  in  log2(MSG_DEPTH)+1  message length, sampled on an accepted `start`.
- `scroll_en`  in  1  selects scroll mode, sampled on an accepted `start`.
- `start`  in  1  single-cycle request to begin output.
- `stop`  in  1  abort request; returns the block to IDLE.
- `busy`  out  1  high in CLEAR, SEND and HOLD.
- `clear`  out  1  display clear strobe, one cycle per frame.
- `char_out`  out  8  ASCII character.
- `char_valid`  out  1  qualifies `char_out`.

## Operation

- **Outputs and reset.** All outputs are registered. While `rst`=0 on a clock edge:
  - state goes to IDLE;
  - `busy`, `clear`, `char_valid` and `char_out` go to 0;
  - scroll offset goes to 0;
  - every buffer byte goes to 0x20.
- **Buffer writes.** `wr_en` writes `wr_data` to `buf[wr_addr]` in any state. A character is read from the buffer in the SEND cycle that emits it, so a write during a frame affects only characters not yet sent.
- **Latched frame parameters.** On an accepted `start`:
  - L = min(`msg_len`, MSG_DEPTH);
  - mode = `scroll_en`.
- **Virtual sequence.** S has length L+1: S[j] = buf[j] for j < L, and S[L] = 0x20.
  - Static mode: digit k (0..7) shows S[k] if k ≤ L, otherwise 0x20.
  - Scroll mode: digit k shows S[(offset+k) mod (L+1)]. The index is kept incrementally and wraps to 0 after reaching L; no divider is used.
- **State machine.**
  - IDLE: `start`=1 latches the frame parameters, sets offset to 0 and moves to CLEAR. Otherwise the block stays in IDLE.
  - CLEAR: `clear`=1 for one cycle, character counter cnt set to 0, then move to SEND.
  - SEND: `char_valid`=1 with `char_out` = digit cnt. cnt increments each cycle. After cnt=7, go to IDLE in static mode or to HOLD in scroll mode.
  - HOLD: lasts exactly SCROLL_DIV cycles. It then advances offset by 1, wrapping to 0 after L, and moves to CLEAR.
- **Priority and collisions.**
  - `stop`=1 in any state forces IDLE on the next edge, drops all strobes and leaves any partial frame on the display. `stop` wins over `start` in the same cycle.
  - `start` while `busy`=1 is ignored.
- **Edge lengths.**
  - L=0: static mode sends 8 spaces; scroll mode sends all-space frames.
  - `msg_len` > MSG_DEPTH is clamped to MSG_DEPTH.

## Timing

- `start` sampled at edge T:
  - `clear`=1 in cycle T+1;
  - `char_valid`=1 in cycles T+2 through T+9 (digit 0 through digit 7);
  - `busy`=1 from T+1 through T+9.
- Static mode: `busy`=0 at T+10, and a new `start` is accepted at T+10.
- Scroll mode: HOLD covers cycles T+10 through T+9+SCROLL_DIV. The next `clear` is in cycle T+10+SCROLL_DIV, so the frame period is SCROLL_DIV+9 cycles.
- `clear` and `char_valid` are never high in the same cycle. No gap cycles occur inside a frame.
- `stop` sampled at edge T: `busy`=`clear`=`char_valid`=0 in cycle T+1.

## Test plan

- **Reset:** hold `rst`=0 for 2 cycles mid-frame → all outputs 0 the cycle after; a following static `start` with L=0 emits eight 0x20.
- **Static frame:** write "HELLO" to addresses 0-4, `msg_len`=5, `scroll_en`=0, pulse `start` → one `clear`, then 48 45 4C 4C 4F 20 20 20 in consecutive cycles; `busy` low 10 cycles after `start`.
- **Scroll:** message "AB", `msg_len`=2, SCROLL_DIV=4 → frames "AB AB AB", then "B AB AB ", then " AB AB A", with the fourth frame equal to the first; each `clear` 13 cycles after the previous.
- **Stop mid-frame:** assert `stop` while the 3rd character is out → next cycle `char_valid`=0 and `busy`=0, and no further `clear` appears.
- **Length clamp:** `msg_len`=20 with MSG_DEPTH=16 in scroll mode → wrap occurs after index 16 (17-entry ring).
- **Collisions:** `start` while `busy`=1 → ignored and the frame content is unchanged. `start`+`stop` in the same cycle from IDLE → stays IDLE. `wr_en` to address 7 during SEND of digit 2 → digit 7 shows the new byte.

Source files
------------

// File: rtl/seg7_msg_writer.sv
// seg7_msg_writer
// Feeds a host-written ASCII message to the 7-segment display controller.
// Each frame is one clear strobe followed by eight char_valid characters.
// Static mode sends one frame. Scroll mode keeps re-sending an 8-character
// window that moves by one position after every SCROLL_DIV hold cycles.
//
// Ports:
//   clk_500hz  display scan clock (only clock)
//   rst        synchronous reset, active low
//   wr_en      message buffer write strobe (accepted in any state)
//   wr_addr    buffer byte address
//   wr_data    ASCII byte to write
//   msg_len    message length, sampled on an accepted start
//   scroll_en  scroll mode select, sampled on an accepted start
//   start      begin output (ignored while busy)
//   stop       abort to IDLE (wins over start)
//   busy       high in CLEAR, SEND and HOLD
//   clear      display clear strobe, one cycle per frame
//   char_out   ASCII character
//   char_valid qualifies char_out
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start
// CLEAR | clear strobe on the outputs
// SEND  | one character per cycle on the outputs, digit cnt
// HOLD  | scroll mode only: SCROLL_DIV cycles between frames
module seg7_msg_writer #(
  parameter int MSG_DEPTH  = 16,
  parameter int SCROLL_DIV = 250
) (
  input  logic                         clk_500hz,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
  input  logic [7:0]                   wr_data,
  input  logic [$clog2(MSG_DEPTH):0]   msg_len,
  input  logic                         scroll_en,
  input  logic                         start,
  input  logic                         stop,
  output logic                         busy,
  output logic                         clear,
  output logic [7:0]                   char_out,
  output logic                         char_valid
);

  localparam int AW = $clog2(MSG_DEPTH);
  localparam int HW = $clog2(SCROLL_DIV + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [AW:0] DEPTH_L = MSG_DEPTH[AW:0];

  logic [1:0]    state;
  logic [7:0]    msg_buf [MSG_DEPTH];
  logic [AW:0]   len;
  logic          mode;
  logic [AW:0]   offset;
  logic [AW:0]   idx;
  logic [2:0]    cnt;
  logic [HW-1:0] hold_cnt;

  logic [AW:0]   len_clamp;
  logic [AW:0]   rd_idx;
  logic [AW:0]   nxt_idx;
  logic [7:0]    rd_char;

  // Outputs are registered, so the character for the next cycle is fetched
  // on the edge before it appears. In CLEAR that is digit 0 (at offset);
  // in SEND it is the running index. A write landing on the same edge is
  // forwarded so it still counts as "not yet sent".
  always_comb begin
    len_clamp = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
    rd_idx    = (state == CLEAR) ? offset : idx;
    if (rd_idx >= len)
      rd_char = 8'h20;
    else if (wr_en && (wr_addr == rd_idx[AW-1:0]))
      rd_char = wr_data;
    else
      rd_char = msg_buf[rd_idx[AW-1:0]];
    // Scroll walks an (L+1)-entry ring; static just counts up and reads
    // spaces past the end.
    nxt_idx = (mode && (rd_idx == len)) ? '0 : rd_idx + 1'b1;
  end

  always_ff @(posedge clk_500hz) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      clear      <= 1'b0;
      char_valid <= 1'b0;
      char_out   <= 8'h00;
      offset     <= '0;
      idx        <= '0;
      len        <= '0;
      mode       <= 1'b0;
      cnt        <= 3'd0;
      hold_cnt   <= '0;
      for (int i = 0; i < MSG_DEPTH; i++) msg_buf[i] <= 8'h20;
    end else begin
      if (wr_en) msg_buf[wr_addr] <= wr_data;
      clear      <= 1'b0;
      char_valid <= 1'b0;
      if (stop) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              len    <= len_clamp;
              mode   <= scroll_en;
              offset <= '0;
              clear  <= 1'b1;
              busy   <= 1'b1;
              state  <= CLEAR;
            end
          end
          CLEAR: begin
            char_out   <= rd_char;
            char_valid <= 1'b1;
            idx        <= nxt_idx;
            cnt        <= 3'd0;
            state      <= SEND;
          end
          SEND: begin
            if (cnt == 3'd7) begin
              if (mode) begin
                hold_cnt <= HW'(SCROLL_DIV - 1);
                state    <= HOLD;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              char_out   <= rd_char;
              char_valid <= 1'b1;
              idx        <= nxt_idx;
              cnt        <= cnt + 3'd1;
            end
          end
          HOLD: begin
            if (hold_cnt == '0) begin
              offset <= (offset == len) ? '0 : offset + 1'b1;
              clear  <= 1'b1;
              state  <= CLEAR;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
